hazard_stall_controller: RTL and testbench

- Decode-stage interlock for the 32-bit pipelined CPU; replaces hand-inserted NOPs in instruction-memory programs.
- Owns the ID/EX instruction register, tracks in-flight destination registers in a small scoreboard, and stalls fetch/decode on read-after-write hazards.
- Squashes the decode slot when EX reports a taken branch.

---
 rtl/hazard_stall_controller.sv | 100 ++++++++++
 tb/tb_hazard_stall_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: decode-stage RAW interlock that owns ID/EX, tracks
// in-flight writers in a small countdown scoreboard, and squashes decode on taken branches.
module hazard_stall_controller #(
    parameter int ALU_LAT = 2,
    parameter int LD_LAT  = 2,
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic        ex_branch_taken,
    output logic        stall_fetch,
    output logic        flush,
    output logic        issue_valid,
    output logic [31:0] issue_instr,
    output logic        sb_full,
    output logic [15:0] stall_cycles
);
    localparam logic [2:0] L_ALU = 3'(ALU_LAT);
    localparam logic [2:0] L_LD  = 3'(LD_LAT);

    logic [ENTRIES-1:0] r_v;
    logic [5:0]         r_reg [ENTRIES];
    logic [2:0]         r_cnt [ENTRIES];
    logic               r_issue_valid;
    logic [31:0]        r_issue_instr;
    logic [15:0]        r_stall_cycles;

    logic [3:0]         w_op;
    logic [5:0]         w_rd;
    logic [5:0]         w_rs;
    logic [5:0]         w_rt;
    logic               w_writer;
    logic               w_use_rs;
    logic               w_use_rt;
    logic               w_match;
    logic               w_hazard;
    logic               w_alloc;
    logic [2:0]         w_lat;
    logic [ENTRIES-1:0] w_free;
    logic [ENTRIES-1:0] w_pick;

    always_comb begin
        w_op     = id_instr[31:28];
        w_rd     = id_instr[27:22];
        w_rs     = id_instr[21:16];
        w_rt     = id_instr[15:10];
        w_writer = w_op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hE, 4'hF};
        w_use_rs = w_op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hE, 4'hB, 4'h9};
        w_use_rt = w_op inside {4'h4, 4'h7};
        w_lat    = (w_op == 4'hE) ? L_LD : L_ALU;
        w_match  = 1'b0;
        w_free   = '0;
        // an entry whose count expires at this edge may be reused at the same edge
        for (int i = 0; i < ENTRIES; i++) begin
            w_free[i] = !r_v[i] || (r_cnt[i] == 3'd1);
            w_match   = w_match || (r_v[i] && ((w_use_rs && r_reg[i] == w_rs) ||
                                               (w_use_rt && r_reg[i] == w_rt)));
        end
        w_pick      = w_free & (~w_free + ENTRIES'(1));
        sb_full     = &r_v;
        flush       = ex_branch_taken;
        w_hazard    = id_valid && !flush && (w_match || (w_writer && sb_full));
        stall_fetch = w_hazard;
        w_alloc     = id_valid && !flush && !w_hazard && w_writer && (w_lat != 3'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v            <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_reg[i] <= '0;
                r_cnt[i] <= '0;
            end
            r_issue_valid  <= 1'b0;
            r_issue_instr  <= '0;
            r_stall_cycles <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (r_v[i]) begin
                    r_cnt[i] <= r_cnt[i] - 3'd1;
                    if (r_cnt[i] == 3'd1) r_v[i] <= 1'b0;
                end
                if (w_alloc && w_pick[i]) begin
                    r_v[i]   <= 1'b1;
                    r_reg[i] <= w_rd;
                    r_cnt[i] <= w_lat;
                end
            end
            r_issue_valid <= id_valid && !flush && !w_hazard;
            r_issue_instr <= (flush || w_hazard) ? 32'd0 : id_instr;
            if (w_hazard && r_stall_cycles != 16'hFFFF) r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign issue_valid  = r_issue_valid;
    assign issue_instr  = r_issue_instr;
    assign stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: two configurations (default, and ALU_LAT=7/ENTRIES=2)
// driven in lockstep and checked against a release-time reference model.
module tb_hazard_stall_controller;
    localparam int ALU [2] = '{2, 7};
    localparam int ENT [2] = '{4, 2};
    localparam int LDL = 2;

    typedef struct packed {
        logic        v;
        logic [31:0] ins;
        logic        br;
        logic        e_sf;
        logic [31:0] e_ii;
        logic [15:0] e_sc;
    } vec_t;

    logic        clk, rst_n, id_valid, ex_branch_taken;
    logic [31:0] id_instr;
    logic        sf [2];
    logic        fl [2];
    logic        iv [2];
    logic        sbf [2];
    logic [31:0] ii [2];
    logic [15:0] sc [2];

    int n_checks = 0;
    int n_pass = 0;

    int          edges;
    int          m_n [2];
    logic [5:0]  m_reg [2][16];
    int          m_exp [2][16];
    logic        e_iv [2];
    logic [31:0] e_ii [2];
    logic [15:0] e_sc [2];

    hazard_stall_controller u_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_branch_taken(ex_branch_taken), .stall_fetch(sf[0]), .flush(fl[0]),
        .issue_valid(iv[0]), .issue_instr(ii[0]), .sb_full(sbf[0]), .stall_cycles(sc[0])
    );

    hazard_stall_controller #(.ALU_LAT(7), .LD_LAT(2), .ENTRIES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_branch_taken(ex_branch_taken), .stall_fetch(sf[1]), .flush(fl[1]),
        .issue_valid(iv[1]), .issue_instr(ii[1]), .sb_full(sbf[1]), .stall_cycles(sc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic writes(input logic [3:0] op);
        return op == 4'h4 || op == 4'h5 || op == 4'h6 || op == 4'h7 || op == 4'hE || op == 4'hF;
    endfunction

    function automatic logic reads_rs(input logic [3:0] op);
        return op == 4'h4 || op == 4'h5 || op == 4'h6 || op == 4'h7 || op == 4'hE ||
               op == 4'hB || op == 4'h9;
    endfunction

    function automatic logic reads_rt(input logic [3:0] op);
        return op == 4'h4 || op == 4'h7;
    endfunction

    // a writer is outstanding until its release edge; consumers stall while any match is outstanding
    function automatic logic m_hazard(input int d);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < m_n[d]; k++)
            if ((reads_rs(id_instr[31:28]) && m_reg[d][k] == id_instr[21:16]) ||
                (reads_rt(id_instr[31:28]) && m_reg[d][k] == id_instr[15:10])) hit = 1'b1;
        return id_valid && !ex_branch_taken && (hit || (writes(id_instr[31:28]) && m_n[d] >= ENT[d]));
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_n[d]  = 0;
            e_iv[d] = 1'b0;
            e_ii[d] = '0;
            e_sc[d] = '0;
        end
    endtask

    task automatic m_edge();
        logic hz [2];
        int   j;
        int   lat;
        for (int d = 0; d < 2; d++) hz[d] = m_hazard(d);
        edges++;
        for (int d = 0; d < 2; d++) begin
            j = 0;
            for (int k = 0; k < m_n[d]; k++)
                if (m_exp[d][k] > edges) begin
                    m_exp[d][j] = m_exp[d][k];
                    m_reg[d][j] = m_reg[d][k];
                    j++;
                end
            m_n[d] = j;
            if (ex_branch_taken) begin
                e_iv[d] = 1'b0;
                e_ii[d] = '0;
            end else if (hz[d]) begin
                e_iv[d] = 1'b0;
                e_ii[d] = '0;
                if (e_sc[d] != 16'hFFFF) e_sc[d] = e_sc[d] + 16'd1;
            end else begin
                e_iv[d] = id_valid;
                e_ii[d] = id_instr;
                lat = (id_instr[31:28] == 4'hE) ? LDL : ALU[d];
                if (id_valid && writes(id_instr[31:28]) && lat > 0) begin
                    m_reg[d][m_n[d]] = id_instr[27:22];
                    m_exp[d][m_n[d]] = edges + lat;
                    m_n[d]++;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("stall_fetch[%0d]", d), 32'(sf[d]), 32'(m_hazard(d)));
            chk($sformatf("flush[%0d]", d), 32'(fl[d]), 32'(ex_branch_taken));
            chk($sformatf("sb_full[%0d]", d), 32'(sbf[d]), 32'(m_n[d] >= ENT[d]));
            chk($sformatf("issue_valid[%0d]", d), 32'(iv[d]), 32'(e_iv[d]));
            chk($sformatf("issue_instr[%0d]", d), ii[d], e_ii[d]);
            chk($sformatf("stall_cycles[%0d]", d), 32'(sc[d]), 32'(e_sc[d]));
        end
    endtask

    task automatic drive_check(input logic v, input logic [31:0] ins, input logic br);
        id_valid        = v;
        id_instr        = ins;
        ex_branch_taken = br;
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        id_valid        = 1'b0;
        id_instr        = '0;
        ex_branch_taken = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    vec_t vt [22];
    int   stalls;
    logic done;

    initial begin
        edges = 0;
        vt = '{
            '{1'b1, 32'hE1820000, 1'b0, 1'b0, 32'hE1820000, 16'd0},
            '{1'b1, 32'h41041800, 1'b0, 1'b1, 32'h00000000, 16'd1},
            '{1'b1, 32'h41041800, 1'b0, 1'b1, 32'h00000000, 16'd2},
            '{1'b1, 32'h41041800, 1'b0, 1'b0, 32'h41041800, 16'd2},
            '{1'b1, 32'h50820400, 1'b0, 1'b0, 32'h50820400, 16'd2},
            '{1'b1, 32'h72021400, 1'b0, 1'b1, 32'h00000000, 16'd3},
            '{1'b1, 32'h72021400, 1'b0, 1'b1, 32'h00000000, 16'd4},
            '{1'b1, 32'h72021400, 1'b0, 1'b0, 32'h72021400, 16'd4},
            '{1'b1, 32'h71041000, 1'b0, 1'b0, 32'h71041000, 16'd4},
            '{1'b1, 32'h41420C00, 1'b0, 1'b0, 32'h41420C00, 16'd4},
            '{1'b1, 32'h50450000, 1'b0, 1'b1, 32'h00000000, 16'd5},
            '{1'b1, 32'h50450000, 1'b1, 1'b0, 32'h00000000, 16'd5},
            '{1'b1, 32'h50450000, 1'b0, 1'b0, 32'h50450000, 16'd5},
            '{1'b1, 32'hF2400001, 1'b0, 1'b0, 32'hF2400001, 16'd5},
            '{1'b1, 32'h20000000, 1'b0, 1'b0, 32'h20000000, 16'd5},
            '{1'b1, 32'h20000000, 1'b0, 1'b0, 32'h20000000, 16'd5},
            '{1'b1, 32'h20000000, 1'b0, 1'b0, 32'h20000000, 16'd5},
            '{1'b1, 32'hB0090000, 1'b0, 1'b0, 32'hB0090000, 16'd5},
            '{1'b1, 32'hF2400001, 1'b0, 1'b0, 32'hF2400001, 16'd5},
            '{1'b1, 32'h20000000, 1'b0, 1'b0, 32'h20000000, 16'd5},
            '{1'b1, 32'hB0090000, 1'b0, 1'b1, 32'h00000000, 16'd6},
            '{1'b1, 32'hB0090000, 1'b0, 1'b0, 32'hB0090000, 16'd6}
        };
        do_reset();
        for (int i = 0; i < 22; i++) begin
            drive_check(vt[i].v, vt[i].ins, vt[i].br);
            chk($sformatf("vec%0d stall_fetch", i), 32'(sf[0]), 32'(vt[i].e_sf));
            chk($sformatf("vec%0d flush", i), 32'(fl[0]), 32'(vt[i].br));
            tick();
            chk($sformatf("vec%0d issue_instr", i), ii[0], vt[i].e_ii);
            chk($sformatf("vec%0d stall_cycles", i), 32'(sc[0]), 32'(vt[i].e_sc));
        end

        // reset asserted in the middle of a load-use stall
        drive_check(1'b1, 32'hE1820000, 1'b0);
        tick();
        drive_check(1'b1, 32'h41041800, 1'b0);
        chk("rst_mid pre stall", 32'(sf[0]), 32'd1);
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_mid issue_valid[%0d]", d), 32'(iv[d]), 32'd0);
            chk($sformatf("rst_mid issue_instr[%0d]", d), ii[d], 32'd0);
            chk($sformatf("rst_mid stall_cycles[%0d]", d), 32'(sc[d]), 32'd0);
            chk($sformatf("rst_mid sb_full[%0d]", d), 32'(sbf[d]), 32'd0);
            chk($sformatf("rst_mid stall_fetch[%0d]", d), 32'(sf[d]), 32'd0);
        end
        tick();
        rst_n = 1'b1;
        drive_check(1'b1, 32'h41041800, 1'b0);
        chk("rst_release no stall", 32'(sf[0]), 32'd0);
        tick();
        chk("rst_release issue", ii[0], 32'h41041800);

        // small scoreboard: third back-to-back writer waits for the oldest entry to expire
        do_reset();
        drive_check(1'b1, 32'hF0400000, 1'b0);
        tick();
        drive_check(1'b1, 32'hF0800000, 1'b0);
        tick();
        stalls = 0;
        done   = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            drive_check(1'b1, 32'hF0C00000, 1'b0);
            if (sf[1]) begin
                stalls++;
                chk("sbB full during stall", 32'(sbf[1]), 32'd1);
            end else done = 1'b1;
            tick();
        end
        chk("sbB stall ended", 32'(done), 32'd1);
        chk("sbB stall count", 32'(stalls), 32'd6);
        chk("sbB third issue", ii[1], 32'hF0C00000);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive_check(($urandom % 8) != 0,
                        {4'($urandom_range(0, 15)), 6'($urandom_range(0, 3)),
                         6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 10'($urandom)},
                        ($urandom % 10) == 0);
            tick();
        end
        drive_check(1'b0, 32'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
